decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage for the 16-bit, 4-bit-opcode core. It accepts one instruction per cycle over a valid/ready handshake and decodes it into a registered control/operand bundle. Immediates are sign- or zero-extended to the datapath width. Instructions that read a pending load result are held by a load-use interlock, and the stage supports a branch flush. It sits between fetch and execute.

---
 rtl/decode_stage_if.sv | 52 +++++
 rtl/decode_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// +--------------------------------------------------------------------+
// | decode_stage_if : fetch-side and execute-side handshake bundles     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [3:0]        out_opcode;
    logic [3:0]        out_alu_op;
    logic [2:0]        out_rd;
    logic [2:0]        out_rs1;
    logic [2:0]        out_rs2;
    logic [DATA_W-1:0] out_imm;
    logic              out_reg_write;
    logic              out_alu_src2;
    logic              out_mem_write;
    logic              out_mem_to_reg;
    logic              out_reg_src;
    logic              out_branch;
    logic              out_illegal;

    // Stage view: consumes fetch traffic, produces the decoded bundle.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready,
        output out_valid, out_pc, out_opcode, out_alu_op, out_rd, out_rs1, out_rs2,
               out_imm, out_reg_write, out_alu_src2, out_mem_write, out_mem_to_reg,
               out_reg_src, out_branch, out_illegal
    );

    // Environment view: fetch drives the instruction, execute drives ready.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready,
        input  out_valid, out_pc, out_opcode, out_alu_op, out_rd, out_rs1, out_rs2,
               out_imm, out_reg_write, out_alu_src2, out_mem_write, out_mem_to_reg,
               out_reg_src, out_branch, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// +--------------------------------------------------------------------+
// | decode_stage : registered decode with load-use interlock and flush  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_stage #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 16,
    parameter int LOAD_DELAY = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        flush,
    output logic [15:0]      perf_stalls,
    decode_stage_if.slave    bus
);
    localparam logic [2:0] c_load_delay = LOAD_DELAY[2:0];

    logic [3:0]        w_opcode, w_alu_op;
    logic [2:0]        w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_imm;
    logic              w_reg_write, w_alu_src2, w_mem_write, w_mem_to_reg;
    logic              w_reg_src, w_branch, w_illegal;
    logic              w_use_rs1, w_use_rs2, w_use_rd;
    logic              w_held_lw, w_hazard, w_in_xfer, w_out_xfer;
    logic [2:0]        r_ld_rd, r_ld_cnt;

    logic [DATA_W-1:0] w_sext6, w_zext6, w_sext9;
    assign w_sext6 = {{(DATA_W-6){bus.in_instr[5]}}, bus.in_instr[5:0]};
    assign w_zext6 = {{(DATA_W-6){1'b0}}, bus.in_instr[5:0]};
    assign w_sext9 = {{(DATA_W-9){bus.in_instr[8]}}, bus.in_instr[8:0]};

    always_comb begin
        w_opcode     = bus.in_instr[15:12];
        w_rd         = bus.in_instr[11:9];
        w_rs1        = bus.in_instr[8:6];
        w_rs2        = bus.in_instr[5:3];
        w_alu_op     = 4'd0;
        w_imm        = '0;
        w_reg_write  = 1'b0;
        w_alu_src2   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_src    = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_use_rd     = 1'b0;
        case (bus.in_instr[15:12])
            4'h0: begin
                w_reg_write = 1'b1; w_mem_to_reg = 1'b1; w_alu_src2 = 1'b1;
                w_imm = w_sext6; w_use_rs1 = 1'b1;
            end
            4'h1: begin
                w_mem_write = 1'b1; w_alu_src2 = 1'b1;
                w_imm = w_sext6; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
            end
            4'h2, 4'h4, 4'h6, 4'h7: begin
                w_reg_write = 1'b1; w_reg_src = 1'b1;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                case (bus.in_instr[14:12])
                    3'd4:    w_alu_op = 4'd2;
                    3'd6:    w_alu_op = 4'd3;
                    3'd7:    w_alu_op = 4'd8;
                    default: w_alu_op = 4'd0;
                endcase
            end
            4'h3, 4'h5, 4'h8, 4'h9: begin
                w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_reg_src = 1'b1;
                w_use_rs1 = 1'b1;
                case (bus.in_instr[15:12])
                    4'h5:    begin w_alu_op = 4'd2; w_imm = w_sext6; end
                    4'h8:    begin w_alu_op = 4'd4; w_imm = w_zext6; end
                    4'h9:    begin w_alu_op = 4'd5; w_imm = w_zext6; end
                    default: begin w_alu_op = 4'd0; w_imm = w_sext6; end
                endcase
            end
            4'hA, 4'hB: begin
                w_branch = 1'b1; w_alu_src2 = 1'b1; w_imm = w_sext9; w_use_rd = 1'b1;
                w_alu_op = bus.in_instr[12] ? 4'd7 : 4'd6;
            end
            default: begin
                // Illegal opcodes travel downstream as an all-zero bundle with only the flag set.
                w_illegal = 1'b1;
                w_opcode  = 4'd0;
                w_rd      = 3'd0;
                w_rs1     = 3'd0;
                w_rs2     = 3'd0;
            end
        endcase
    end

    assign w_held_lw = bus.out_valid && bus.out_mem_to_reg;

    always_comb begin
        w_hazard = 1'b0;
        if (w_use_rs1 && ((w_held_lw && w_rs1 == bus.out_rd) || (r_ld_cnt != 3'd0 && w_rs1 == r_ld_rd)))
            w_hazard = 1'b1;
        if (w_use_rs2 && ((w_held_lw && w_rs2 == bus.out_rd) || (r_ld_cnt != 3'd0 && w_rs2 == r_ld_rd)))
            w_hazard = 1'b1;
        if (w_use_rd && ((w_held_lw && w_rd == bus.out_rd) || (r_ld_cnt != 3'd0 && w_rd == r_ld_rd)))
            w_hazard = 1'b1;
    end

    assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready) && !w_hazard && !flush;
    assign w_in_xfer    = bus.in_valid && bus.in_ready;
    assign w_out_xfer   = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_pc         <= '0;
            bus.out_opcode     <= 4'd0;
            bus.out_alu_op     <= 4'd0;
            bus.out_rd         <= 3'd0;
            bus.out_rs1        <= 3'd0;
            bus.out_rs2        <= 3'd0;
            bus.out_imm        <= '0;
            bus.out_reg_write  <= 1'b0;
            bus.out_alu_src2   <= 1'b0;
            bus.out_mem_write  <= 1'b0;
            bus.out_mem_to_reg <= 1'b0;
            bus.out_reg_src    <= 1'b0;
            bus.out_branch     <= 1'b0;
            bus.out_illegal    <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (w_in_xfer) begin
            bus.out_valid      <= 1'b1;
            bus.out_pc         <= bus.in_pc;
            bus.out_opcode     <= w_opcode;
            bus.out_alu_op     <= w_alu_op;
            bus.out_rd         <= w_rd;
            bus.out_rs1        <= w_rs1;
            bus.out_rs2        <= w_rs2;
            bus.out_imm        <= w_imm;
            bus.out_reg_write  <= w_reg_write;
            bus.out_alu_src2   <= w_alu_src2;
            bus.out_mem_write  <= w_mem_write;
            bus.out_mem_to_reg <= w_mem_to_reg;
            bus.out_reg_src    <= w_reg_src;
            bus.out_branch     <= w_branch;
            bus.out_illegal    <= w_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Single pending-load entry; a newer lw simply overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rd  <= 3'd0;
            r_ld_cnt <= 3'd0;
        end else if (flush) begin
            r_ld_cnt <= 3'd0;
        end else if (w_out_xfer && bus.out_mem_to_reg) begin
            r_ld_rd  <= bus.out_rd;
            r_ld_cnt <= c_load_delay;
        end else if (r_ld_cnt != 3'd0) begin
            r_ld_cnt <= r_ld_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stalls <= 16'd0;
        else if (bus.in_valid && w_hazard && !flush && perf_stalls != 16'hFFFF)
            perf_stalls <= perf_stalls + 16'd1;
    end
endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// +--------------------------------------------------------------------+
// | tb_decode_stage : table-driven decode vectors plus interlock cases  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] perf_stalls;
    int          total = 0;
    int          bad = 0;

    decode_stage_if #(.DATA_W(16), .PC_W(16)) bus ();

    decode_stage #(.DATA_W(16), .PC_W(16), .LOAD_DELAY(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .perf_stalls (perf_stalls),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // ctl = {reg_write, alu_src2, mem_write, mem_to_reg, reg_src, branch, illegal}
    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op;
        logic [3:0]  alu;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [6:0]  ctl;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.out_reg_write, bus.out_alu_src2, bus.out_mem_write, bus.out_mem_to_reg,
                bus.out_reg_src, bus.out_branch, bus.out_illegal};
    endfunction

    initial begin
        logic [15:0] p0;
        logic [15:0] held_pc;

        tbl[0]  = '{16'h2A4C, 4'h2, 4'd0, 3'd5, 3'd1, 3'd1, 16'h0000, 7'b1000100};
        tbl[1]  = '{16'h4A4C, 4'h4, 4'd2, 3'd5, 3'd1, 3'd1, 16'h0000, 7'b1000100};
        tbl[2]  = '{16'h6A4C, 4'h6, 4'd3, 3'd5, 3'd1, 3'd1, 16'h0000, 7'b1000100};
        tbl[3]  = '{16'h7A4C, 4'h7, 4'd8, 3'd5, 3'd1, 3'd1, 16'h0000, 7'b1000100};
        tbl[4]  = '{16'h3283, 4'h3, 4'd0, 3'd1, 3'd2, 3'd0, 16'h0003, 7'b1100100};
        tbl[5]  = '{16'h52BF, 4'h5, 4'd2, 3'd1, 3'd2, 3'd7, 16'hFFFF, 7'b1100100};
        tbl[6]  = '{16'h923F, 4'h9, 4'd5, 3'd1, 3'd0, 3'd7, 16'h003F, 7'b1100100};
        tbl[7]  = '{16'h8220, 4'h8, 4'd4, 3'd1, 3'd0, 3'd4, 16'h0020, 7'b1100100};
        tbl[8]  = '{16'hA1FF, 4'hA, 4'd6, 3'd0, 3'd7, 3'd7, 16'hFFFF, 7'b0100010};
        tbl[9]  = '{16'hB0FF, 4'hB, 4'd7, 3'd0, 3'd3, 3'd7, 16'h00FF, 7'b0100010};
        tbl[10] = '{16'h1A7E, 4'h1, 4'd0, 3'd5, 3'd1, 3'd7, 16'hFFFE, 7'b0110000};
        tbl[11] = '{16'hC123, 4'h0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 7'b0000001};
        tbl[12] = '{16'h0A7E, 4'h0, 4'd0, 3'd5, 3'd1, 3'd7, 16'hFFFE, 7'b1101000};

        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h2A4C;
        bus.in_pc     = 16'h0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_fields", {33'd0, bus.out_imm, bus.out_opcode, bus.out_rd, ctl_now()}, 64'd0);
        chk("rst_perf", {48'd0, perf_stalls}, 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming decode table, one instruction per cycle
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = tbl[i].instr;
            bus.in_pc    = 16'h0100 + 16'(i * 2);
            #1;
            chk($sformatf("in_ready[%0d]", i), {63'd0, bus.in_ready}, 64'd1);
            @(negedge clk);
            chk($sformatf("valid[%0d]", i), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("pc[%0d]", i), {48'd0, bus.out_pc}, {48'd0, 16'h0100 + 16'(i * 2)});
            chk($sformatf("fields[%0d]", i),
                {30'd0, bus.out_opcode, bus.out_alu_op, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, ctl_now()},
                {30'd0, tbl[i].op, tbl[i].alu, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].ctl});
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_valid", {63'd0, bus.out_valid}, 64'd0);

        // Load-use interlock with LOAD_DELAY=1
        bus.in_valid = 1'b1; bus.in_instr = 16'h0A7E; bus.in_pc = 16'h0200;
        @(negedge clk);
        chk("lu_lw_imm", {48'd0, bus.out_imm}, 64'hFFFE);
        bus.in_instr = 16'h2B40; bus.in_pc = 16'h0202;
        #1;
        p0 = perf_stalls;
        chk("lu_stall1", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk); #1;
        chk("lu_stall2", {63'd0, bus.in_ready}, 64'd0);
        chk("lu_bubble", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk); #1;
        chk("lu_issue_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("lu_perf", {48'd0, perf_stalls - p0}, 64'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("lu_add_out", {56'd0, bus.out_valid, bus.out_opcode, bus.out_rd}, {56'd0, 1'b1, 4'h2, 3'd5});
        repeat (3) @(negedge clk);

        // Illegal opcode held by backpressure
        bus.in_valid = 1'b1; bus.in_instr = 16'hF000; bus.in_pc = 16'h0300;
        bus.out_ready = 1'b0;
        @(negedge clk);
        held_pc = bus.out_pc;
        chk("ill_flag", {55'd0, bus.out_valid, ctl_now(), bus.out_opcode}, {55'd0, 1'b1, 7'b0000001, 4'h0});
        bus.in_instr = 16'h2A4C; bus.in_pc = 16'h0302;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ill_hold_ready[%0d]", k), {63'd0, bus.in_ready}, 64'd0);
            @(negedge clk);
            chk($sformatf("ill_hold[%0d]", k), {31'd0, bus.out_valid, bus.out_illegal, held_pc, bus.out_pc},
                {31'd0, 1'b1, 1'b1, 16'h0300, 16'h0300});
        end
        bus.out_ready = 1'b1;
        #1;
        chk("ill_release_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        chk("ill_next", {40'd0, bus.out_valid, bus.out_illegal, bus.out_opcode, bus.out_pc},
            {40'd0, 1'b1, 1'b0, 4'h2, 16'h0302});
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Flush while a lw is held and a dependent instruction waits
        bus.in_valid = 1'b1; bus.in_instr = 16'h0A7E; bus.in_pc = 16'h0400;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_instr = 16'h2B40; bus.in_pc = 16'h0402;
        #1;
        chk("fl_wait", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        p0 = perf_stalls;
        flush = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("fl_ready_during", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_perf", {48'd0, perf_stalls}, {48'd0, p0});
        #1;
        chk("fl_sb_clear", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        chk("fl_dep_out", {40'd0, bus.out_valid, bus.out_opcode, bus.out_pc}, {40'd0, 1'b1, 4'h2, 16'h0402});
        chk("fl_perf_after", {48'd0, perf_stalls}, {48'd0, p0});
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-operation discards the held bundle at once
        bus.in_valid = 1'b1; bus.in_instr = 16'h0A7E; bus.in_pc = 16'h0500;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mr_held", {63'd0, bus.out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_cleared", {46'd0, bus.out_valid, bus.in_ready, perf_stalls}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
